// File: rtl/io_pkg.sv
// Shared definitions for the CPU IO-port UART blocks (TX now, RX later).
package io_pkg;

  localparam int IO_BYTE_W                = 8;
  localparam int UART_CLK_PER_BIT_DEFAULT = 868;  // 100 MHz / 115200 baud

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered ready and an occupancy count.
// Ready is computed from the next-cycle level, so it is never high while full.
// Read data is the word at the read pointer; a word written at edge N can be
// popped at edge N+1 at the earliest because pop decisions use the registered level.
module sync_fifo #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push,
  input  logic [DW-1:0] din,
  output logic          rdy,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          empty,
  output logic [AW:0]   level
);

  localparam int         DEPTH = 1 << AW;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level_next;
  logic          push_ok;
  logic          pop_ok;

  assign push_ok = push && rdy;
  assign pop_ok  = pop && !empty;
  assign empty   = (level == '0);
  assign dout    = mem[rd_ptr];

  // Occupancy after this edge; a simultaneous push and pop cancel out.
  always_comb begin
    level_next = level;
    if (push_ok && !pop_ok) begin
      level_next = level + (AW+1)'(1);
    end else if (!push_ok && pop_ok) begin
      level_next = level - (AW+1)'(1);
    end
  end

  // Pointers, level and registered ready; pointers wrap naturally at 2^AW.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      rdy    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      level <= level_next;
      rdy   <= (level_next != FULL);
    end
  end

  // Storage array; contents need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/io_uart_tx.sv
// UART transmitter for the CPU output byte stream: valid/ready in, 8N1 out.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | line high, waiting for a buffered byte
// START | start bit (low) for CLK_PER_BIT cycles
// DATA  | 8 data bits LSB first, CLK_PER_BIT cycles each
// STOP  | stop bit (high); chains straight into START if more data waits
module io_uart_tx
  import io_pkg::*;
#(
  parameter int CLK_PER_BIT = UART_CLK_PER_BIT_DEFAULT,
  parameter int FIFO_AW     = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [IO_BYTE_W-1:0] io_out_data,
  input  logic                 io_out_vld,
  output logic                 io_out_rdy,
  output logic                 txd,
  output logic                 busy,
  output logic [FIFO_AW:0]     fifo_level
);

  localparam logic [15:0] BAUD_LOAD = 16'(CLK_PER_BIT - 1);

  uart_state_t          state, state_n;
  logic [15:0]          baud_cnt, baud_cnt_n;
  logic [2:0]           bit_idx, bit_idx_n;
  logic [IO_BYTE_W-1:0] shifter, shifter_n;
  logic                 txd_q, txd_n;
  logic                 pop;
  logic                 fifo_empty;
  logic [IO_BYTE_W-1:0] fifo_dout;

  sync_fifo #(
    .DW (IO_BYTE_W),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (io_out_vld),
    .din   (io_out_data),
    .rdy   (io_out_rdy),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign txd  = txd_q;
  assign busy = (state != IDLE) || (fifo_level != '0);

  // Frame sequencing; txd_n is the line value for the coming cycle so the pin is registered.
  always_comb begin
    state_n    = state;
    baud_cnt_n = baud_cnt;
    bit_idx_n  = bit_idx;
    shifter_n  = shifter;
    txd_n      = txd_q;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        txd_n = 1'b1;
        if (!fifo_empty) begin
          pop        = 1'b1;
          shifter_n  = fifo_dout;
          baud_cnt_n = BAUD_LOAD;
          state_n    = START;
          txd_n      = 1'b0;
        end
      end
      START: begin
        txd_n = 1'b0;
        if (baud_cnt == '0) begin
          state_n    = DATA;
          bit_idx_n  = 3'd0;
          baud_cnt_n = BAUD_LOAD;
          txd_n      = shifter[0];
        end else begin
          baud_cnt_n = baud_cnt - 16'd1;
        end
      end
      DATA: begin
        txd_n = shifter[0];
        if (baud_cnt == '0) begin
          shifter_n  = shifter >> 1;
          baud_cnt_n = BAUD_LOAD;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
            txd_n   = 1'b1;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
            txd_n     = shifter_n[0];
          end
        end else begin
          baud_cnt_n = baud_cnt - 16'd1;
        end
      end
      STOP: begin
        txd_n = 1'b1;
        if (baud_cnt == '0) begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            shifter_n  = fifo_dout;
            baud_cnt_n = BAUD_LOAD;
            state_n    = START;
            txd_n      = 1'b0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          baud_cnt_n = baud_cnt - 16'd1;
        end
      end
      default: begin
        state_n = IDLE;
        txd_n   = 1'b1;
      end
    endcase
  end

  // State register; reset aborts any frame in flight and forces the line high.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shifter  <= '0;
      txd_q    <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_cnt_n;
      bit_idx  <= bit_idx_n;
      shifter  <= shifter_n;
      txd_q    <= txd_n;
    end
  end

endmodule

// File: tb/tb_io_uart_tx.sv
// Directed bench for io_uart_tx with a byte scoreboard and a txd frame decoder.
module tb_io_uart_tx;

  localparam int CPB = 4;
  localparam int AW  = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  io_out_data = 8'h00;
  logic        io_out_vld = 1'b0;
  logic        io_out_rdy;
  logic        txd;
  logic        busy;
  logic [AW:0] fifo_level;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] sb[$];
  int         cyc_cnt = 0;
  bit         in_frame = 1'b0;
  int         fcyc = 0;
  logic [7:0] rx = 8'h00;
  int         frames_done = 0;
  int         last_start = 0;
  int         prev_start = 0;

  always #5 clk = ~clk;

  io_uart_tx #(
    .CLK_PER_BIT (CPB),
    .FIFO_AW     (AW)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .io_out_data (io_out_data),
    .io_out_vld  (io_out_vld),
    .io_out_rdy  (io_out_rdy),
    .txd         (txd),
    .busy        (busy),
    .fifo_level  (fifo_level)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, want);
    end
  endtask

  // Frame decoder: start detected on first low sample, bits sampled mid-bit.
  always @(negedge clk) begin
    logic [7:0] want_b;
    cyc_cnt++;
    if (!rstn) begin
      in_frame = 1'b0;
    end else if (!in_frame) begin
      if (txd === 1'b0) begin
        in_frame   = 1'b1;
        fcyc       = 0;
        rx         = 8'h00;
        prev_start = last_start;
        last_start = cyc_cnt;
      end
    end else begin
      fcyc++;
      if (fcyc >= 6 && fcyc <= 34 && ((fcyc - 6) % 4) == 0) begin
        rx = {txd, rx[7:1]};
      end
      if (fcyc == 38) begin
        chk("stop_bit", 32'(txd), 32'd1);
        chk("sb_has_entry", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          want_b = sb.pop_front();
          chk("rx_byte", 32'(rx), 32'(want_b));
        end
        frames_done++;
      end
      if (fcyc == 39) in_frame = 1'b0;
    end
  end

  task automatic send(input logic [7:0] b);
    int t = 0;
    io_out_vld  = 1'b1;
    io_out_data = b;
    while (io_out_rdy !== 1'b1 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("send_wait", 32'(t < 1000), 32'd1);
    sb.push_back(b);
    @(negedge clk);
    io_out_vld = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((busy || in_frame || sb.size() != 0) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("idle_wait", 32'(t < 5000), 32'd1);
  endtask

  initial begin
    logic [9:0] frame;
    int         fr;
    int         acc;
    bit         took;
    bit         quiet;
    int         t;

    // Reset state
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_txd", 32'(txd), 32'd1);
    chk("rst_rdy", 32'(io_out_rdy), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("rdy_after_rst", 32'(io_out_rdy), 32'd1);

    // Single byte 0x55: push latency and exact waveform
    io_out_vld  = 1'b1;
    io_out_data = 8'h55;
    sb.push_back(8'h55);
    @(negedge clk);
    io_out_vld = 1'b0;
    chk("push_rdy", 32'(io_out_rdy), 32'd1);
    chk("push_level1", 32'(fifo_level), 32'd1);
    chk("push_txd_hi", 32'(txd), 32'd1);
    chk("push_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("pop_level0", 32'(fifo_level), 32'd0);
    frame = {1'b1, 8'h55, 1'b0};
    for (int j = 0; j < 40; j++) begin
      chk("wave55", 32'(txd), 32'(frame[j / CPB]));
      if (j == 39) chk("busy_last_stop", 32'(busy), 32'd1);
      @(negedge clk);
    end
    chk("txd_idle_after", 32'(txd), 32'd1);
    chk("busy_fall", 32'(busy), 32'd0);

    // Back-to-back 0xA5, 0x3C
    fr = frames_done;
    send(8'hA5);
    send(8'h3C);
    wait_idle();
    chk("b2b_frames", 32'(frames_done - fr), 32'd2);
    chk("b2b_gap", 32'(last_start - prev_start), 32'd40);

    // Fill from reset release with vld held high
    rstn = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);
    fr          = frames_done;
    rstn        = 1'b1;
    io_out_vld  = 1'b1;
    io_out_data = 8'h00;
    acc         = 0;
    took        = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (took) io_out_data = io_out_data + 8'd1;
      took = io_out_rdy;
      if (io_out_rdy) begin
        sb.push_back(io_out_data);
        acc++;
      end else if (acc > 0) begin
        break;
      end
    end
    chk("fill_transfers", 32'(acc), 32'd17);
    chk("fill_level", 32'(fifo_level), 32'd16);

    // Toggle vld while full: nothing may be taken
    for (int k = 0; k < 6; k++) begin
      io_out_vld = k[0];
      @(negedge clk);
      chk("full_level", 32'(fifo_level), 32'd16);
      chk("full_rdy", 32'(io_out_rdy), 32'd0);
    end
    io_out_vld = 1'b0;
    t = 0;
    while (io_out_rdy !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("rdy_back_wait", 32'(t < 200), 32'd1);
    chk("rdy_back_level", 32'(fifo_level), 32'd15);
    wait_idle();
    chk("fill_frames", 32'(frames_done - fr), 32'd17);
    chk("fill_sb_empty", 32'(sb.size()), 32'd0);

    // Reset in the middle of DATA bit 3 with 5 bytes queued
    for (int k = 0; k < 6; k++) send(8'(8'hC0 + k));
    chk("abort_level", 32'(fifo_level), 32'd5);
    t = 0;
    while (!(in_frame && fcyc >= 17) && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("abort_wait", 32'(t < 200), 32'd1);
    rstn = 1'b0;
    sb.delete();
    fr = frames_done;
    @(negedge clk);
    chk("abort_txd", 32'(txd), 32'd1);
    chk("abort_fifo", 32'(fifo_level), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_rdy", 32'(io_out_rdy), 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("abort_rdy_next", 32'(io_out_rdy), 32'd1);
    quiet = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (txd !== 1'b1) quiet = 1'b0;
    end
    chk("abort_quiet", 32'(quiet), 32'd1);
    chk("abort_no_frames", 32'(frames_done - fr), 32'd0);
    chk("abort_level_end", 32'(fifo_level), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
